// File: rtl/pwm_multi_shadow.sv
// pwm_multi_shadow: shared-counter multi-channel PWM with shadowed period/compare committed at period boundaries
module pwm_multi_shadow #(
  parameter int WIDTH      = 8,
  parameter int CH         = 4,
  parameter int PERIOD_RST = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_center,
  input  logic                period_wr,
  input  logic [WIDTH-1:0]    period_data,
  input  logic [CH-1:0]       cmp_wr,
  input  logic [CH*WIDTH-1:0] cmp_data,
  input  logic [CH-1:0]       pol,
  input  logic [CH-1:0]       out_en,
  output logic [CH-1:0]       pwm_out,
  output logic                period_start,
  output logic                update_pending
);
  logic [WIDTH-1:0]    r_cnt, r_p_act, r_p_sh;
  logic                r_dir, r_mode, r_ps, r_up;
  logic [CH*WIDTH-1:0] r_cmp_act, r_cmp_sh;
  logic [CH-1:0]       r_pwm;
  logic [WIDTH-1:0]    w_p_next, w_cnt_next;
  logic [CH*WIDTH-1:0] w_cmp_next;
  logic [CH-1:0]       w_raw;
  logic                w_wrap, w_turn, w_bnd;

  // coincident writes bypass the shadow so a boundary write commits immediately
  assign w_p_next = period_wr ? period_data : r_p_sh;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign w_cmp_next[i*WIDTH +: WIDTH] = cmp_wr[i] ? cmp_data[i*WIDTH +: WIDTH] : r_cmp_sh[i*WIDTH +: WIDTH];
    assign w_raw[i] = r_cnt < r_cmp_act[i*WIDTH +: WIDTH];
  end

  // wrap: P=0, edge top, center descent reaching 0, or center P=1 turning straight to 0
  assign w_wrap = (r_p_act == '0)
                | (!r_mode && r_cnt >= r_p_act)
                | (r_mode && (r_dir ? r_cnt <= WIDTH'(1) : (r_cnt >= r_p_act && r_p_act == WIDTH'(1))));
  assign w_turn = r_mode && !r_dir && r_cnt >= r_p_act;
  assign w_bnd  = enable && w_wrap;
  assign w_cnt_next = w_wrap ? '0 : w_turn ? r_p_act - WIDTH'(1) : r_dir ? r_cnt - WIDTH'(1) : r_cnt + WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_mode    <= 1'b0;
      r_p_act   <= WIDTH'(PERIOD_RST);
      r_p_sh    <= WIDTH'(PERIOD_RST);
      r_cmp_act <= '0;
      r_cmp_sh  <= '0;
      r_pwm     <= '0;
      r_ps      <= 1'b0;
      r_up      <= 1'b0;
    end else begin
      r_p_sh   <= w_p_next;
      r_cmp_sh <= w_cmp_next;
      r_up     <= w_bnd ? 1'b0 : (r_up | period_wr | (|cmp_wr));
      r_ps     <= w_bnd;
      if (enable) begin
        r_cnt <= w_cnt_next;
        r_dir <= w_wrap ? 1'b0 : (w_turn | r_dir);
        r_pwm <= (w_raw ^ pol) & out_en;
        if (w_wrap) begin
          r_p_act   <= w_p_next;
          r_mode    <= cfg_center;
          r_cmp_act <= w_cmp_next;
        end
      end
    end
  end

  assign pwm_out        = r_pwm;
  assign period_start   = r_ps;
  assign update_pending = r_up;
endmodule

// File: tb/tb_pwm_multi_shadow.sv
// tb_pwm_multi_shadow: per-period high-time scoreboard plus directed checks of shadow, freeze and reset behaviour
module tb_pwm_multi_shadow;
  logic        clk = 0, reset = 1, enable = 0, cfg_center = 0, period_wr = 0;
  logic [7:0]  period_data = 0;
  logic [3:0]  cmp_wr = 0, pol = 0, out_en = 4'hF;
  logic [31:0] cmp_data = 0;
  logic [3:0]  pwm_out;
  logic        period_start, update_pending, en_q = 0;
  typedef struct { int h0, h1, h2, h3, len; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  pwm_multi_shadow #(.WIDTH(8), .CH(4), .PERIOD_RST(13)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_center(cfg_center),
    .period_wr(period_wr), .period_data(period_data), .cmp_wr(cmp_wr), .cmp_data(cmp_data),
    .pol(pol), .out_en(out_en), .pwm_out(pwm_out), .period_start(period_start),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) en_q <= enable;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input int b, input int c, input int d, input int l);
    exp_t e;
    e.h0 = a; e.h1 = b; e.h2 = c; e.h3 = d; e.len = l;
    q.push_back(e);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 100);
    if (!period_start) chk("ps_timeout", 0, 1);
    #1;
  endtask

  // monitor: accumulates enabled-cycle high time per channel, scores each finished period
  initial begin : monitor
    int acc[4];
    int len;
    exp_t e;
    len = 0;
    acc = '{default: 0};
    forever begin
      @(negedge clk);
      if (en_q) begin
        len++;
        for (int i = 0; i < 4; i++) acc[i] += int'(pwm_out[i]);
      end
      if (period_start) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("win_len", len, e.len);
          chk("win_ch0", acc[0], e.h0);
          chk("win_ch1", acc[1], e.h1);
          chk("win_ch2", acc[2], e.h2);
          chk("win_ch3", acc[3], e.h3);
        end
        len = 0;
        acc = '{default: 0};
      end
    end
  end

  initial begin
    pol = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_up", int'(update_pending), 0);
    @(posedge clk); #1;
    reset = 0; pol = 0;
    period_wr = 1; period_data = 9; cmp_wr = 4'hF; cmp_data = {8'd10, 8'd0, 8'd7, 8'd3};
    clk_n(1); period_wr = 0; cmp_wr = 0;
    @(negedge clk);
    chk("up_set_disabled", int'(update_pending), 1);
    chk("ps_disabled", int'(period_start), 0);
    #1 enable = 1;
    sync_ps();
    chk("up_clr_first", int'(update_pending), 0);
    repeat (3) push(3, 7, 0, 10, 10);
    repeat (3) sync_ps();
    pol = 4'b1100;
    push(3, 7, 10, 0, 10);
    sync_ps();
    pol = 4'b1000; out_en = 4'b0111;
    push(3, 7, 0, 0, 10);
    sync_ps();
    pol = 0; out_en = 4'hF;
    push(3, 7, 0, 10, 10);
    push(7, 7, 0, 10, 10);
    clk_n(4);
    cmp_wr = 4'b0001; cmp_data[7:0] = 7;
    clk_n(1); cmp_wr = 0;
    @(negedge clk);
    chk("up_mid_write", int'(update_pending), 1);
    sync_ps();
    chk("up_clr_boundary", int'(update_pending), 0);
    clk_n(9);
    cmp_wr = 4'b0001; cmp_data[7:0] = 5;
    clk_n(1); cmp_wr = 0;
    @(negedge clk);
    chk("bypass_ps", int'(period_start), 1);
    chk("bypass_up", int'(update_pending), 0);
    #1 push(5, 7, 0, 10, 10);
    cfg_center = 1; period_wr = 1; period_data = 4; cmp_wr = 4'b0001; cmp_data[7:0] = 2;
    repeat (2) push(3, 8, 0, 8, 8);
    clk_n(1); period_wr = 0; cmp_wr = 0;
    @(negedge clk);
    chk("up_center_write", int'(update_pending), 1);
    repeat (3) sync_ps();
    cfg_center = 0; period_wr = 1; period_data = 9;
    push(3, 8, 0, 8, 8);
    push(2, 7, 0, 10, 10);
    clk_n(1); period_wr = 0;
    sync_ps();
    clk_n(5);
    enable = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("freeze_pwm", int'(pwm_out), 4'b1010);
      chk("freeze_ps", int'(period_start), 0);
    end
    #1 enable = 1;
    sync_ps();
    clk_n(3);
    period_wr = 1; period_data = 5; cmp_wr = 4'b0001; cmp_data[7:0] = 9;
    clk_n(1); period_wr = 0; cmp_wr = 0;
    @(negedge clk);
    chk("pre_rst_up", int'(update_pending), 1);
    chk("pre_rst_pwm", int'(pwm_out), 4'b1010);
    #2 reset = 1;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_up", int'(update_pending), 0);
    chk("async_rst_ps", int'(period_start), 0);
    clk_n(2);
    reset = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_rst_pwm", int'(pwm_out), 0);
      chk("post_rst_ps", int'(period_start), int'(i == 14));
    end
    #1;
    period_wr = 1; period_data = 0; cmp_wr = 4'b0001; cmp_data[7:0] = 1;
    push(0, 0, 0, 0, 14);
    repeat (3) push(1, 0, 0, 0, 1);
    clk_n(1); period_wr = 0; cmp_wr = 0;
    for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clk);
    #1;
    if (q.size() > 0) chk("drain", q.size(), 0);
    @(negedge clk);
    chk("p0_ps_every_clk", int'(period_start), 1);
    chk("p0_pwm", int'(pwm_out), 4'b0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
